// File: rtl/rgb_block_mapper_if.sv
// -----------------------------------------------------------------------------
// rgb_block_mapper_if
// Groups the pixel-stream input and the mapped-pixel output of
// rgb_block_mapper into one bundle.
//   master : pixel source side. It drives rgb/hsync/vsync/empty/rgb_enable/
//            chan_swap and observes the mapped outputs.
//   slave  : mapper side. It consumes the stream and drives pixel_data,
//            pixel_valid, the four coordinates, frame_done and line_err.
// Coordinate widths are ceil(log2(N)), with a minimum of 1 bit.
// -----------------------------------------------------------------------------
interface rgb_block_mapper_if #(
    parameter int CW        = 8,
    parameter int PIX_COLS  = 8,
    parameter int PIX_LINES = 16,
    parameter int BLK_COLS  = 5,
    parameter int BLK_LINES = 3
);
    localparam int PCW = (PIX_COLS  > 1) ? $clog2(PIX_COLS)  : 1;
    localparam int PLW = (PIX_LINES > 1) ? $clog2(PIX_LINES) : 1;
    localparam int BCW = (BLK_COLS  > 1) ? $clog2(BLK_COLS)  : 1;
    localparam int BLW = (BLK_LINES > 1) ? $clog2(BLK_LINES) : 1;

    logic [3*CW-1:0] rgb;
    logic            hsync;
    logic            vsync;
    logic            empty;
    logic            rgb_enable;
    logic            chan_swap;

    logic [3*CW-1:0] pixel_data;
    logic            pixel_valid;
    logic [PCW-1:0]  pixel_col;
    logic [PLW-1:0]  pixel_line;
    logic [BCW-1:0]  block_col;
    logic [BLW-1:0]  block_line;
    logic            frame_done;
    logic            line_err;

    modport master (
        output rgb, hsync, vsync, empty, rgb_enable, chan_swap,
        input  pixel_data, pixel_valid, pixel_col, pixel_line,
               block_col, block_line, frame_done, line_err
    );

    modport slave (
        input  rgb, hsync, vsync, empty, rgb_enable, chan_swap,
        output pixel_data, pixel_valid, pixel_col, pixel_line,
               block_col, block_line, frame_done, line_err
    );
endinterface

// File: rtl/rgb_block_mapper.sv
// -----------------------------------------------------------------------------
// rgb_block_mapper
// Maps a raster pixel stream, taken from a FIFO, onto a frame made of
// BLK_COLS x BLK_LINES micro-blocks. Each micro-block is PIX_COLS x PIX_LINES
// pixels. Every issued pixel is tagged with its pixel/block coordinates.
// Channel order can be reversed. Every output is registered and appears one
// cycle after the accepting sample.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rgb_block_mapper_if.slave. Inputs are rgb/hsync/vsync/empty/
//          rgb_enable/chan_swap. Outputs are pixel_data/pixel_valid/
//          pixel_col/pixel_line/block_col/block_line/frame_done/line_err.
//
// Build option
//   RGB_LINE_CHECK_EN : compiles in line-length checking, which drives
//                       line_err. When the macro is undefined, line_err is
//                       constant 0 and hsync falls do not touch the counters.
// -----------------------------------------------------------------------------
module rgb_block_mapper #(
    parameter int CW        = 8,
    parameter int PIX_COLS  = 8,
    parameter int PIX_LINES = 16,
    parameter int BLK_COLS  = 5,
    parameter int BLK_LINES = 3
) (
    input  logic               clk,
    input  logic               rst,
    rgb_block_mapper_if.slave  bus
);
    localparam int PCW = (PIX_COLS  > 1) ? $clog2(PIX_COLS)  : 1;
    localparam int PLW = (PIX_LINES > 1) ? $clog2(PIX_LINES) : 1;
    localparam int BCW = (BLK_COLS  > 1) ? $clog2(BLK_COLS)  : 1;
    localparam int BLW = (BLK_LINES > 1) ? $clog2(BLK_LINES) : 1;

    localparam logic [PCW-1:0] PC_LAST = PCW'(PIX_COLS  - 1);
    localparam logic [PLW-1:0] PL_LAST = PLW'(PIX_LINES - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(BLK_COLS  - 1);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLK_LINES - 1);
    localparam logic [PCW-1:0] PC_ONE  = PCW'(1);
    localparam logic [PLW-1:0] PL_ONE  = PLW'(1);
    localparam logic [BCW-1:0] BC_ONE  = BCW'(1);
    localparam logic [BLW-1:0] BL_ONE  = BLW'(1);

    // Stream tracking state.
    logic           vsync_q,    vsync_d;
    logic           hsync_q,    hsync_d;
    logic           frame_en_q, frame_en_d;
    // Coordinates of the next pixel to be issued.
    logic [PCW-1:0] pc_q, pc_d;
    logic [PLW-1:0] pl_q, pl_d;
    logic [BCW-1:0] bc_q, bc_d;
    logic [BLW-1:0] bl_q, bl_d;
    // Output registers.
    logic [3*CW-1:0] data_q,  data_d;
    logic            valid_q, valid_d;
    logic [PCW-1:0]  opc_q,   opc_d;
    logic [PLW-1:0]  opl_q,   opl_d;
    logic [BCW-1:0]  obc_q,   obc_d;
    logic [BLW-1:0]  obl_q,   obl_d;
    logic            done_q,  done_d;
    logic            err_q,   err_d;

    // Decoded sample events and derived values.
    logic            accept_s;
    logic            vs_rise_s;
    logic            pixel_s;
    logic            frame_en_s;
    logic [3*CW-1:0] data_sel_s;
    logic [PCW-1:0]  ipc_s, npc_s;
    logic [PLW-1:0]  ipl_s, npl_s;
    logic [BCW-1:0]  ibc_s, nbc_s;
    logic [BLW-1:0]  ibl_s, nbl_s;
    logic            line_wrap_s;
    logic            frame_last_s;

`ifdef RGB_LINE_CHECK_EN
    // Set once a line has wrapped. Cleared by the next hsync fall.
    logic           pend_q, pend_d;
    logic           hs_fall_s;
    logic [PLW-1:0] apl_s;
    logic [BLW-1:0] abl_s;
`endif

    // Decode the sample. A vsync rise forces the issued coordinates to 0 and
    // reloads frame_en for this same sample.
    always_comb begin
        accept_s   = ~bus.empty;
        vs_rise_s  = accept_s & bus.vsync & ~vsync_q;
        pixel_s    = accept_s & bus.vsync & bus.hsync;
        if (vs_rise_s) begin
            frame_en_s = bus.rgb_enable;
            ipc_s      = '0;
            ipl_s      = '0;
            ibc_s      = '0;
            ibl_s      = '0;
        end else begin
            frame_en_s = frame_en_q;
            ipc_s      = pc_q;
            ipl_s      = pl_q;
            ibc_s      = bc_q;
            ibl_s      = bl_q;
        end
        if (bus.chan_swap) begin
            data_sel_s = {bus.rgb[CW-1:0], bus.rgb[2*CW-1:CW], bus.rgb[3*CW-1:2*CW]};
        end else begin
            data_sel_s = bus.rgb;
        end
    end

    // Counter chain: pixel_col -> block_col -> pixel_line -> block_line.
    always_comb begin
        npc_s = ipc_s;
        nbc_s = ibc_s;
        npl_s = ipl_s;
        nbl_s = ibl_s;
        if (ipc_s == PC_LAST) begin
            npc_s = '0;
            if (ibc_s == BC_LAST) begin
                nbc_s = '0;
                if (ipl_s == PL_LAST) begin
                    npl_s = '0;
                    if (ibl_s == BL_LAST) begin
                        nbl_s = '0;
                    end else begin
                        nbl_s = ibl_s + BL_ONE;
                    end
                end else begin
                    npl_s = ipl_s + PL_ONE;
                end
            end else begin
                nbc_s = ibc_s + BC_ONE;
            end
        end else begin
            npc_s = ipc_s + PC_ONE;
        end
        line_wrap_s  = (ipc_s == PC_LAST) && (ibc_s == BC_LAST);
        frame_last_s = line_wrap_s && (ipl_s == PL_LAST) && (ibl_s == BL_LAST);
    end

`ifdef RGB_LINE_CHECK_EN
    // Detect a short-line hsync fall and compute the pixel_line advance with
    // its carry into block_line.
    always_comb begin
        hs_fall_s = accept_s & bus.vsync & hsync_q & ~bus.hsync;
        if (pl_q == PL_LAST) begin
            apl_s = '0;
            if (bl_q == BL_LAST) begin
                abl_s = '0;
            end else begin
                abl_s = bl_q + BL_ONE;
            end
        end else begin
            apl_s = pl_q + PL_ONE;
            abl_s = bl_q;
        end
    end
`endif

    // Next-state and output selection. Every signal holds unless the sample
    // is accepted. Status pulses default to 0.
    always_comb begin
        vsync_d    = vsync_q;
        hsync_d    = hsync_q;
        frame_en_d = frame_en_s;
        pc_d       = pc_q;
        pl_d       = pl_q;
        bc_d       = bc_q;
        bl_d       = bl_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        opc_d      = opc_q;
        opl_d      = opl_q;
        obc_d      = obc_q;
        obl_d      = obl_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef RGB_LINE_CHECK_EN
        pend_d     = pend_q;
`endif
        if (accept_s) begin
            vsync_d = bus.vsync;
            hsync_d = bus.hsync;
        end else begin
            vsync_d = vsync_q;
            hsync_d = hsync_q;
        end
        if (pixel_s) begin
            pc_d    = npc_s;
            pl_d    = npl_s;
            bc_d    = nbc_s;
            bl_d    = nbl_s;
            data_d  = data_sel_s;
            valid_d = frame_en_s;
            opc_d   = ipc_s;
            opl_d   = ipl_s;
            obc_d   = ibc_s;
            obl_d   = ibl_s;
            done_d  = frame_last_s;
`ifdef RGB_LINE_CHECK_EN
            // A new line is starting, but the previous line end never saw
            // an hsync fall.
            err_d   = pend_q & ~vs_rise_s & (ipc_s == PCW'(0)) & (ibc_s == BCW'(0));
            pend_d  = line_wrap_s;
`endif
        end else if (vs_rise_s) begin
            pc_d = '0;
            pl_d = '0;
            bc_d = '0;
            bl_d = '0;
`ifdef RGB_LINE_CHECK_EN
            pend_d = 1'b0;
`endif
`ifdef RGB_LINE_CHECK_EN
        end else if (hs_fall_s) begin
            pend_d = 1'b0;
            if ((pc_q != PCW'(0)) || (bc_q != BCW'(0))) begin
                err_d = 1'b1;
                pc_d  = '0;
                bc_d  = '0;
                pl_d  = apl_s;
                bl_d  = abl_s;
            end else begin
                err_d = 1'b0;
            end
`endif
        end else begin
            pc_d = pc_q;
        end
    end

    // State and output registers. The reset has priority over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            hsync_q    <= 1'b0;
            frame_en_q <= 1'b0;
            pc_q       <= '0;
            pl_q       <= '0;
            bc_q       <= '0;
            bl_q       <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            opc_q      <= '0;
            opl_q      <= '0;
            obc_q      <= '0;
            obl_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef RGB_LINE_CHECK_EN
            pend_q     <= 1'b0;
`endif
        end else begin
            vsync_q    <= vsync_d;
            hsync_q    <= hsync_d;
            frame_en_q <= frame_en_d;
            pc_q       <= pc_d;
            pl_q       <= pl_d;
            bc_q       <= bc_d;
            bl_q       <= bl_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            opc_q      <= opc_d;
            opl_q      <= opl_d;
            obc_q      <= obc_d;
            obl_q      <= obl_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef RGB_LINE_CHECK_EN
            pend_q     <= pend_d;
`endif
        end
    end

    assign bus.pixel_data  = data_q;
    assign bus.pixel_valid = valid_q;
    assign bus.pixel_col   = opc_q;
    assign bus.pixel_line  = opl_q;
    assign bus.block_col   = obc_q;
    assign bus.block_line  = obl_q;
    assign bus.frame_done  = done_q;
    assign bus.line_err    = err_q;
endmodule
